shift_chain_ctrl: RTL



---
 rtl/shift_chain_ctrl_if.sv | 31 +++
 rtl/shift_chain_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_chain_ctrl_if
// Brief   : Register-side bus of the shift-chain controller (write, start/irq, readback)
// Revision: 1.0 - initial release
// ============================================================================
interface shift_chain_ctrl_if #(
  parameter int WIDTH = 24
);
  logic             wr_en;
  logic [2:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic             irq;
  logic             irq_clr;
  logic [2:0]       rd_sel;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_sel, wr_data, start, irq_clr, rd_sel,
    input  busy, done, irq, rd_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, start, irq_clr, rd_sel,
    output busy, done, irq, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/shift_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : shift_chain_ctrl
// Brief   : Full-duplex controller for six output and six input shift chains
// Revision: 1.0 - initial release
// ============================================================================
module shift_chain_ctrl #(
  parameter int WIDTH   = 24,
  parameter int CLK_DIV = 4
) (
  input  logic              sys_clock,
  input  logic              resetn,
  shift_chain_ctrl_if.slave bus,
  output logic [5:0]        sh_dat,
  output logic              sh_clk,
  output logic              sh_stb,
  output logic              lm_ld,
  output logic              lm_ck,
  input  logic [5:0]        lm_d
);
  localparam int c_chains = 6;
  localparam int c_div_w  = $clog2(CLK_DIV + 1);
  localparam int c_bit_w  = $clog2(WIDTH + 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
  localparam logic [2:0]         c_sel_max  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_STROBE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_phase, w_phase_nxt;
  logic [c_div_w-1:0]   r_div, w_div_nxt;
  logic [c_bit_w-1:0]   r_bit, w_bit_nxt;
  logic                 w_div_end;
  logic                 w_load_tx, w_shift_tx, w_sample_rx, w_hold_ld;

  logic [WIDTH-1:0]     r_shadow [c_chains];
  logic [WIDTH-1:0]     r_tx     [c_chains];
  logic [WIDTH-1:0]     w_tx_nxt [c_chains];
  logic [WIDTH-1:0]     r_rx     [c_chains];
  logic [WIDTH-1:0]     r_hold   [c_chains];
  logic [5:0]           w_sh_dat_nxt;

  logic                 r_busy, r_done, r_irq;
  logic                 r_sh_clk, r_sh_stb, r_lm_ld;
  logic [5:0]           r_sh_dat;

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_phase  <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      r_sh_clk <= 1'b0;
      r_sh_stb <= 1'b0;
      r_lm_ld  <= 1'b1;
      r_sh_dat <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_div    <= w_div_nxt;
      r_bit    <= w_bit_nxt;
      // Outputs are registered from the next-state decode so they align with the state
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      r_sh_clk <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
      r_sh_stb <= (w_state_nxt == S_STROBE);
      r_lm_ld  <= (w_state_nxt != S_LOAD);
      r_sh_dat <= w_sh_dat_nxt;
      if (r_state == S_DONE) begin
        r_irq <= 1'b1;
      end else if (bus.irq_clr) begin
        r_irq <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_load_tx   = 1'b0;
    w_shift_tx  = 1'b0;
    w_sample_rx = 1'b0;
    w_hold_ld   = 1'b0;
    w_div_end   = (r_div == '0);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD;
          w_div_nxt   = c_div_last;
        end
      end
      S_LOAD: begin
        w_load_tx = (r_div == c_div_last);
        if (w_div_end) begin
          w_state_nxt = S_SHIFT;
          w_phase_nxt = 1'b0;
          w_bit_nxt   = '0;
          w_div_nxt   = c_div_last;
        end else begin
          w_div_nxt = r_div - c_div_one;
        end
      end
      S_SHIFT: begin
        if (w_div_end) begin
          w_div_nxt = c_div_last;
          if (!r_phase) begin
            w_sample_rx = 1'b1;
            w_phase_nxt = 1'b1;
          end else begin
            w_shift_tx  = 1'b1;
            w_phase_nxt = 1'b0;
            if (r_bit == c_bit_last) begin
              w_state_nxt = S_STROBE;
            end else begin
              w_bit_nxt = r_bit + c_bit_one;
            end
          end
        end else begin
          w_div_nxt = r_div - c_div_one;
        end
      end
      S_STROBE: begin
        if (w_div_end) begin
          w_state_nxt = S_DONE;
        end else begin
          w_div_nxt = r_div - c_div_one;
        end
      end
      S_DONE: begin
        w_hold_ld   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    for (int i = 0; i < c_chains; i++) begin
      if (w_load_tx) begin
        w_tx_nxt[i] = r_shadow[i];
      end else if (w_shift_tx) begin
        w_tx_nxt[i] = {r_tx[i][WIDTH-2:0], 1'b0};
      end else begin
        w_tx_nxt[i] = r_tx[i];
      end
      w_sh_dat_nxt[i] = (w_state_nxt == S_SHIFT) ? w_tx_nxt[i][WIDTH-1] : 1'b0;
    end
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < c_chains; i++) begin
        r_shadow[i] <= '0;
        r_tx[i]     <= '0;
        r_rx[i]     <= '0;
        r_hold[i]   <= '0;
      end
    end else begin
      if (bus.wr_en && (bus.wr_sel <= c_sel_max)) begin
        r_shadow[bus.wr_sel] <= bus.wr_data;
      end
      for (int i = 0; i < c_chains; i++) begin
        r_tx[i] <= w_tx_nxt[i];
        if (w_sample_rx) begin
          r_rx[i] <= {r_rx[i][WIDTH-2:0], lm_d[i]};
        end
        if (w_hold_ld) begin
          r_hold[i] <= r_rx[i];
        end
      end
    end
  end

  assign bus.rd_data = (bus.rd_sel <= c_sel_max) ? r_hold[bus.rd_sel] : '0;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.irq     = r_irq;
  assign sh_dat      = r_sh_dat;
  assign sh_clk      = r_sh_clk;
  assign lm_ck       = r_sh_clk;
  assign sh_stb      = r_sh_stb;
  assign lm_ld       = r_lm_ld;

endmodule
`default_nettype wire
